// File: rtl/eth_rx_addr_filter.sv
// rtl/eth_rx_addr_filter.sv - receive destination-address filter; define ETH_RX_FILTER_MCAST_EN to also accept group addresses
module eth_rx_addr_filter #(
  parameter bit ACCEPT_BROADCAST = 1'b1,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [47:0]                 local_mac,
  input  logic                        promisc,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  output logic [7:0]                  m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        frame_accept,
  output logic                        frame_drop,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PASS, ST_FLUSH, ST_DROP} state_t;

  state_t      state, state_n;
  logic [2:0]  hcnt, hcnt_n;
  logic [2:0]  fcnt, fcnt_n;
  logic        ovr_mid, ovr_mid_n, ovr_after;
  logic        tuser_q;
  logic [7:0]  hdr [6];
  logic [47:0] dest;
  logic        mcast_hit, addr_hit;
  logic        hdr_wr, hdr_shift, emit, emit_last, drop_set, cap_tuser;

  // Destination seen at the decision beat: five buffered bytes plus the byte on the bus
  assign dest = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_axis_tdata};

`ifdef ETH_RX_FILTER_MCAST_EN
  assign mcast_hit = hdr[0][0];
`else
  assign mcast_hit = 1'b0;
`endif

  assign addr_hit = (dest == local_mac) || (ACCEPT_BROADCAST && (&dest)) || promisc || mcast_hit;

  // State register and header/flush counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hcnt    <= 3'd0;
      fcnt    <= 3'd0;
      ovr_mid <= 1'b0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      fcnt    <= fcnt_n;
      ovr_mid <= ovr_mid_n;
    end
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    fcnt_n    = fcnt;
    ovr_mid_n = ovr_mid;
    ovr_after = ovr_mid;
    hdr_wr    = 1'b0;
    hdr_shift = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    drop_set  = 1'b0;
    cap_tuser = 1'b0;
    case (state)
      ST_IDLE, ST_HDR: begin
        if (s_axis_tvalid) begin
          hdr_wr = 1'b1;
          if (s_axis_tlast) begin
            // Frame ended inside the header: runt
            drop_set = 1'b1;
            hcnt_n   = 3'd0;
            state_n  = ST_IDLE;
          end else if (hcnt == 3'd5) begin
            hcnt_n = 3'd0;
            if (addr_hit) begin
              state_n = ST_PASS;
            end else begin
              state_n  = ST_DROP;
              drop_set = 1'b1;
            end
          end else begin
            hcnt_n  = hcnt + 3'd1;
            state_n = ST_HDR;
          end
        end
      end
      ST_PASS: begin
        if (s_axis_tvalid) begin
          hdr_shift = 1'b1;
          emit      = 1'b1;
          if (s_axis_tlast) begin
            cap_tuser = 1'b1;
            fcnt_n    = 3'd6;
            ovr_mid_n = 1'b0;
            state_n   = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Drain the six buffered bytes; any input beat now belongs to a frame we cannot buffer
        emit      = 1'b1;
        hdr_shift = 1'b1;
        fcnt_n    = fcnt - 3'd1;
        if (s_axis_tvalid) begin
          drop_set  = !ovr_mid;
          ovr_after = !s_axis_tlast;
        end
        ovr_mid_n = ovr_after;
        if (fcnt == 3'd1) begin
          emit_last = 1'b1;
          ovr_mid_n = 1'b0;
          hcnt_n    = 3'd0;
          state_n   = ovr_after ? ST_DROP : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          hcnt_n  = 3'd0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        hcnt_n  = 3'd0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // Header buffer: indexed fill during the header, shift register while passing/flushing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) hdr[i] <= 8'h00;
      tuser_q <= 1'b0;
    end else begin
      if (hdr_wr) begin
        for (int i = 0; i < 6; i++) begin
          if (hcnt == 3'(i)) hdr[i] <= s_axis_tdata;
        end
      end else if (hdr_shift) begin
        for (int i = 0; i < 5; i++) hdr[i] <= hdr[i+1];
        hdr[5] <= s_axis_tdata;
      end
      if (cap_tuser) tuser_q <= s_axis_tuser;
    end
  end

  // Registered output stream, status pulses and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_accept  <= 1'b0;
      frame_drop    <= 1'b0;
      drop_count    <= '0;
    end else begin
      m_axis_tvalid <= emit;
      m_axis_tlast  <= emit_last;
      m_axis_tuser  <= emit_last & tuser_q;
      frame_accept  <= emit_last;
      frame_drop    <= drop_set;
      if (emit) m_axis_tdata <= hdr[0];
      if (drop_set && !(&drop_count)) drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
    end
  end

endmodule
